// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, response and shared-memory signals of the arbiter, grouped into one bundle.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              iReq0;
  logic              iReq1;
  logic              iWe0;
  logic              iWe1;
  logic [ADDR_W-1:0] iAddr0;
  logic [ADDR_W-1:0] iAddr1;
  logic [DATA_W-1:0] iWData0;
  logic [DATA_W-1:0] iWData1;
  logic [DATA_W-1:0] oRData0;
  logic [DATA_W-1:0] oRData1;
  logic              oAck0;
  logic              oAck1;
  logic [ADDR_W-1:0] oMemAddr;
  logic [DATA_W-1:0] oMemData;
  logic              oMemRead;
  logic              oMemWrite;
  logic [DATA_W-1:0] iMemData;
  logic              oBusy;
  logic              oOwner;

  modport slave (
    input  iReq0, iReq1, iWe0, iWe1, iAddr0, iAddr1, iWData0, iWData1, iMemData,
    output oRData0, oRData1, oAck0, oAck1, oMemAddr, oMemData, oMemRead, oMemWrite,
           oBusy, oOwner
  );

  modport master (
    output iReq0, iReq1, iWe0, iWe1, iAddr0, iAddr1, iWData0, iWData1, iMemData,
    input  oRData0, oRData1, oAck0, oAck1, oMemAddr, oMemData, oMemRead, oMemWrite,
           oBusy, oOwner
  );

endinterface

// File: rtl/arb_select2.sv
// Two-way grant selection: contention goes to the port not served last.
// With the pointer tied to PORT_DMA this degenerates to fixed priority for port 0.
module arb_select2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  // Winner selection for the current request pair
  always_comb begin
    grant = PORT_CPU;
    valid = req0 | req1;
    if (req0 && req1) begin
      grant = other_port(last);
    end else if (req1) begin
      grant = PORT_DMA;
    end else begin
      grant = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE -> ACCESS (one strobe cycle) -> RESP (ack pulse).
// Define MEM_ARB_RR_EN for round-robin contention; default build is fixed priority (port 0).
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          iClk,
  input  logic          iRst,
  mem_arbiter_if.slave  bus
);

  state_e            state_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              busy_q;

  logic              grant_s;
  logic              grant_valid_s;
  logic              last_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;

  arb_select2 u_sel (
    .req0  (bus.iReq0),
    .req1  (bus.iReq1),
    .last  (last_s),
    .grant (grant_s),
    .valid (grant_valid_s)
  );

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // Round-robin pointer: remembers the port granted most recently
  always_ff @(posedge iClk) begin
    if (iRst) begin
      last_q <= PORT_DMA;
    end else if ((state_q == IDLE) && grant_valid_s) begin
      last_q <= grant_s;
    end else begin
      last_q <= last_q;
    end
  end

  assign last_s = last_q;
`else
  assign last_s = PORT_DMA;
`endif

  // Operands of the winning requester
  always_comb begin
    win_we_s    = bus.iWe0;
    win_addr_s  = bus.iAddr0;
    win_wdata_s = bus.iWData0;
    if (grant_s == PORT_DMA) begin
      win_we_s    = bus.iWe1;
      win_addr_s  = bus.iAddr1;
      win_wdata_s = bus.iWData1;
    end else begin
      win_we_s    = bus.iWe0;
      win_addr_s  = bus.iAddr0;
      win_wdata_s = bus.iWData0;
    end
  end

  // Transaction FSM; every output is a register updated here
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      mem_addr_q <= {ADDR_W{1'b0}};
      mem_data_q <= {DATA_W{1'b0}};
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= {DATA_W{1'b0}};
      rdata1_q   <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (grant_valid_s) begin
            state_q    <= ACCESS;
            owner_q    <= grant_s;
            we_q       <= win_we_s;
            mem_addr_q <= win_addr_s;
            mem_data_q <= win_wdata_s;
            mem_rd_q   <= ~win_we_s;
            mem_wr_q   <= win_we_s;
            busy_q     <= 1'b1;
          end else begin
            state_q  <= IDLE;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        ACCESS: begin
          state_q  <= RESP;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          // Memory data is sampled at the edge closing the strobe cycle
          if (owner_q == PORT_DMA) begin
            ack1_q <= 1'b1;
            if (!we_q) begin
              rdata1_q <= bus.iMemData;
            end
          end else begin
            ack0_q <= 1'b1;
            if (!we_q) begin
              rdata0_q <= bus.iMemData;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          ack0_q   <= 1'b0;
          ack1_q   <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oRData0   = rdata0_q;
  assign bus.oRData1   = rdata1_q;
  assign bus.oAck0     = ack0_q;
  assign bus.oAck1     = ack1_q;
  assign bus.oMemAddr  = mem_addr_q;
  assign bus.oMemData  = mem_data_q;
  assign bus.oMemRead  = mem_rd_q;
  assign bus.oMemWrite = mem_wr_q;
  assign bus.oBusy     = busy_q;
  assign bus.oOwner    = owner_q;

endmodule
